// File: rtl/vend_credit_ctrl.sv
// Credit-accounting controller for the vending machine: accumulates coin credit,
// dispenses when credit covers PRICE, then pays back change one unit per cycle.
module vend_credit_ctrl #(
  parameter int unsigned PRICE = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin1,
  input  logic       coin5,
  input  logic       coin10,
  input  logic       buy,
  input  logic       cancel,
  output logic [4:0] credit,
  output logic [4:0] change,
  output logic       disp_sel,
  output logic       dispense,
  output logic       ret_unit,
  output logic       coin_reject,
  output logic       no_funds
);

  localparam logic [4:0] PRICE_C = PRICE[4:0];

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, RETURN} state_t;

  state_t     state;
  logic       one_coin;
  logic       any_coin;
  logic       coin_ok;
  logic       funds_ok;
  logic [4:0] coin_val;
  logic [5:0] coin_sum;

  always_comb begin
    one_coin = 1'b0;
    coin_val = 5'd0;
    case ({coin10, coin5, coin1})
      3'b001:  begin one_coin = 1'b1; coin_val = 5'd1;  end
      3'b010:  begin one_coin = 1'b1; coin_val = 5'd5;  end
      3'b100:  begin one_coin = 1'b1; coin_val = 5'd10; end
      default: begin one_coin = 1'b0; coin_val = 5'd0;  end
    endcase
    any_coin = coin1 | coin5 | coin10;
    // Bit 5 of the 6-bit sum flags a credit that would exceed 31.
    coin_sum = {1'b0, credit} + {1'b0, coin_val};
    coin_ok  = one_coin & ~coin_sum[5];
    funds_ok = (credit >= PRICE_C);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      credit      <= '0;
      change      <= '0;
      disp_sel    <= 1'b0;
      dispense    <= 1'b0;
      ret_unit    <= 1'b0;
      coin_reject <= 1'b0;
      no_funds    <= 1'b0;
    end else begin
      // NOTE: pulses default here and are overridden below; with non-blocking
      // assignments the last write in this block is the one that lands.
      dispense    <= 1'b0;
      ret_unit    <= 1'b0;
      no_funds    <= 1'b0;
      coin_reject <= any_coin;
      case (state)
        IDLE: begin
          no_funds <= buy;
          if (coin_ok) begin
            credit      <= coin_sum[4:0];
            coin_reject <= 1'b0;
            state       <= COLLECT;
          end
        end
        COLLECT: begin
          if (cancel) begin
            // Credit is never zero here, so the first unit is paid right away.
            change   <= credit - 5'd1;
            credit   <= '0;
            ret_unit <= 1'b1;
            disp_sel <= 1'b1;
            state    <= RETURN;
          end else if (buy && funds_ok) begin
            change   <= credit - PRICE_C;
            credit   <= '0;
            dispense <= 1'b1;
            disp_sel <= 1'b1;
            state    <= VEND;
          end else begin
            no_funds <= buy;
            if (coin_ok) begin
              credit      <= coin_sum[4:0];
              coin_reject <= 1'b0;
            end
          end
        end
        VEND, RETURN: begin
          if (change != 5'd0) begin
            change   <= change - 5'd1;
            ret_unit <= 1'b1;
            state    <= RETURN;
          end else begin
            disp_sel <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Scoreboard bench for vend_credit_ctrl: a timeline model queues expected outputs
// per cycle, a negedge monitor pops and compares; directed cases then random traffic.
module tb_vend_credit_ctrl;

  localparam int PRICE = 15;

  typedef struct {
    int credit;
    int change;
    bit sel;
    bit disp;
    bit ret;
    bit rej;
    bit nf;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin1, coin5, coin10, buy, cancel;
  logic [4:0] credit, change;
  logic       disp_sel, dispense, ret_unit, coin_reject, no_funds;

  exp_t exp_q[$];
  exp_t plan[$];
  exp_t mon_e;
  int   m_credit, m_accepted;
  int   n_disp, n_ret;
  int   errors, checks;
  bit   chk_en;
  bit   r1, r5, r10, rb, rc;

  always #5 clk = ~clk;

  vend_credit_ctrl #(.PRICE(PRICE)) dut (
    .clk(clk), .reset(reset),
    .coin1(coin1), .coin5(coin5), .coin10(coin10), .buy(buy), .cancel(cancel),
    .credit(credit), .change(change), .disp_sel(disp_sel), .dispense(dispense),
    .ret_unit(ret_unit), .coin_reject(coin_reject), .no_funds(no_funds)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input int cr, input int ch, input bit sel, input bit disp, input bit ret);
    exp_t e;
    e.credit = cr; e.change = ch; e.sel = sel; e.disp = disp; e.ret = ret;
    e.rej = 1'b0; e.nf = 1'b0;
    return e;
  endfunction

  // Schedules the payout timeline: units owed counting down to 0, then an idle cycle.
  task automatic schedule_payout(input int from);
    for (int k = from; k >= 0; k--) plan.push_back(mk(0, k, 1'b1, 1'b0, 1'b1));
    plan.push_back(mk(0, 0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic step(input bit c1, input bit c5, input bit c10, input bit b, input bit cx);
    exp_t r;
    bit   any, one;
    int   v, c;
    coin1 = c1; coin5 = c5; coin10 = c10; buy = b; cancel = cx;
    any = c1 | c5 | c10;
    one = (int'(c1) + int'(c5) + int'(c10)) == 1;
    v   = c10 ? 10 : (c5 ? 5 : 1);
    if (plan.size() != 0) begin
      r = plan.pop_front();
      r.rej = any;
    end else if (m_credit > 0 && cx) begin
      r = mk(0, m_credit - 1, 1'b1, 1'b0, 1'b1);
      r.rej = any;
      schedule_payout(m_credit - 2);
      m_credit = 0;
    end else if (m_credit > 0 && b && m_credit >= PRICE) begin
      c = m_credit - PRICE;
      r = mk(0, c, 1'b1, 1'b1, 1'b0);
      r.rej = any;
      schedule_payout(c - 1);
      m_credit = 0;
    end else begin
      r = mk(0, 0, 1'b0, 1'b0, 1'b0);
      r.nf = b;
      if (any) begin
        if (one && m_credit + v <= 31) begin
          m_credit   += v;
          m_accepted += v;
        end else begin
          r.rej = 1'b1;
        end
      end
      r.credit = m_credit;
    end
    exp_q.push_back(r);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (plan.size() != 0 && guard < 80) begin
      step(0, 0, 0, 0, 0);
      guard++;
    end
    check("drain_timeout", plan.size(), 0);
    step(0, 0, 0, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_credit"}, credit, 0);
    check({tag, "_change"}, change, 0);
    check({tag, "_disp_sel"}, disp_sel, 0);
    check({tag, "_dispense"}, dispense, 0);
    check({tag, "_ret_unit"}, ret_unit, 0);
    check({tag, "_coin_reject"}, coin_reject, 0);
    check({tag, "_no_funds"}, no_funds, 0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() == 0) begin
        check("queue_depth", 0, 1);
      end else begin
        mon_e = exp_q.pop_front();
        check("credit", credit, mon_e.credit);
        check("change", change, mon_e.change);
        check("disp_sel", disp_sel, mon_e.sel);
        check("dispense", dispense, mon_e.disp);
        check("ret_unit", ret_unit, mon_e.ret);
        check("coin_reject", coin_reject, mon_e.rej);
        check("no_funds", no_funds, mon_e.nf);
        n_disp += int'(dispense);
        n_ret  += int'(ret_unit);
      end
    end
  end

  initial begin
    errors = 0; checks = 0; chk_en = 1'b0;
    m_credit = 0; m_accepted = 0; n_disp = 0; n_ret = 0;
    reset = 1'b1;
    coin1 = 0; coin5 = 0; coin10 = 0; buy = 0; cancel = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_en = 1'b1;

    // Exact-price purchase: 10 then 5, buy, no change.
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    idle(3);

    // 20 credit, buy: 5 units of change.
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    drain();

    // Overflow boundary near 31, simultaneous coins, then cancel refund.
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    drain();

    // Insufficient funds, then buy+cancel together.
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    drain();

    // Idle buy/cancel, and coins offered during VEND and RETURN.
    step(0, 0, 0, 1, 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    drain();

    // Asynchronous reset in the middle of a payout.
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    idle(2);
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    check("pre_reset_change_nonzero", int'(change != 5'd0), 1);
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    plan.delete();
    m_credit = 0; m_accepted = 0; n_disp = 0; n_ret = 0;
    #1;
    chk_en = 1'b1;

    // Random coin/buy/cancel traffic.
    for (int i = 0; i < 800; i++) begin
      int k;
      k = $urandom_range(0, 19);
      r1 = (k < 4) || (k == 11);
      r5 = (k >= 4 && k < 8) || (k == 12);
      r10 = (k >= 8 && k < 11) || (k == 11) || (k == 12);
      rb = ($urandom_range(0, 6) == 0);
      rc = ($urandom_range(0, 24) == 0);
      step(r1, r5, r10, rb, rc);
    end
    drain();

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    check("queue_empty", exp_q.size(), 0);
    check("conservation", PRICE * n_disp + n_ret + int'(credit), m_accepted);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
